// File: rtl/depar_seg_splitter.sv
// -----------------------------------------------------------------------------
// depar_seg_splitter
//
// Pulls packet beats from a fall-through packet FIFO, gathers the first
// C_NUM_HDR_BEATS beats into one wide header word, extracts the VLAN ID from
// the first beat, then streams the remaining payload beats through a
// registered valid/ready output. Packets that end inside the header window
// ("short" packets) skip the payload phase. Two wrapping counters report the
// number of accepted headers and the number of short packets.
//
// Ports:
//   axis_clk, aresetn        clock, asynchronous active-low reset
//   pkt_fifo_t*              head beat of the fall-through packet FIFO
//   pkt_fifo_empty           FIFO empty flag
//   pkt_fifo_rd_en           pop strobe (head consumed on any cycle it is high)
//   hdr_t*, hdr_valid        gathered header word, beat i at [i*W +: W]
//   hdr_ready, vlan_ready    both must be high together to accept the header
//   vlan_id                  VLAN ID of the current packet
//   seg_t*, seg_valid/ready  registered payload beat stream
//   stat_pkt_cnt             headers accepted
//   stat_short_cnt           packets of at most C_NUM_HDR_BEATS beats
// -----------------------------------------------------------------------------
module depar_seg_splitter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_HDR_BEATS    = 4,
    parameter int C_VLANID_WIDTH     = 12,
    parameter int C_STAT_WIDTH       = 32
) (
    input  logic                                            axis_clk,
    input  logic                                            aresetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]                    pkt_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                   pkt_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]                  pkt_fifo_tkeep,
    input  logic                                            pkt_fifo_tlast,
    input  logic                                            pkt_fifo_empty,
    output logic                                            pkt_fifo_rd_en,

    output logic [C_NUM_HDR_BEATS*C_AXIS_DATA_WIDTH-1:0]    hdr_tdata,
    output logic [C_NUM_HDR_BEATS*C_AXIS_TUSER_WIDTH-1:0]   hdr_tuser,
    output logic [C_NUM_HDR_BEATS*C_AXIS_DATA_WIDTH/8-1:0]  hdr_tkeep,
    output logic [C_NUM_HDR_BEATS-1:0]                      hdr_tlast,
    output logic                                            hdr_valid,
    input  logic                                            hdr_ready,

    output logic [C_VLANID_WIDTH-1:0]                       vlan_id,
    input  logic                                            vlan_ready,

    output logic [C_AXIS_DATA_WIDTH-1:0]                    seg_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                   seg_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                  seg_tkeep,
    output logic                                            seg_tlast,
    output logic                                            seg_valid,
    input  logic                                            seg_ready,

    output logic [C_STAT_WIDTH-1:0]                         stat_pkt_cnt,
    output logic [C_STAT_WIDTH-1:0]                         stat_short_cnt
);

    localparam int DW    = C_AXIS_DATA_WIDTH;
    localparam int UW    = C_AXIS_TUSER_WIDTH;
    localparam int KW    = C_AXIS_DATA_WIDTH / 8;
    localparam int N     = C_NUM_HDR_BEATS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_HDR,
        S_EMIT,
        S_PAYLOAD
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    short_q, short_d;

    logic [N*DW-1:0]         hdr_tdata_q, hdr_tdata_d;
    logic [N*UW-1:0]         hdr_tuser_q, hdr_tuser_d;
    logic [N*KW-1:0]         hdr_tkeep_q, hdr_tkeep_d;
    logic [N-1:0]            hdr_tlast_q, hdr_tlast_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [C_VLANID_WIDTH-1:0] vlan_id_q, vlan_id_d;

    logic [DW-1:0]           seg_tdata_q, seg_tdata_d;
    logic [UW-1:0]           seg_tuser_q, seg_tuser_d;
    logic [KW-1:0]           seg_tkeep_q, seg_tkeep_d;
    logic                    seg_tlast_q, seg_tlast_d;
    logic                    seg_valid_q, seg_valid_d;

    logic [C_STAT_WIDTH-1:0] stat_pkt_cnt_q, stat_pkt_cnt_d;
    logic [C_STAT_WIDTH-1:0] stat_short_cnt_q, stat_short_cnt_d;

    logic                    pop;
    logic                    hdr_xfer;

    // The pop strobe is combinational from the FIFO flags: a fall-through
    // FIFO presents its head beat before it is consumed, so popping has no
    // extra cycle of latency.
    assign pkt_fifo_rd_en = pop;

    // NOTE: always_comb starts by giving every *_d its hold value so no path
    // leaves a signal unassigned; that is what keeps this block latch-free.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        short_d          = short_q;
        hdr_tdata_d      = hdr_tdata_q;
        hdr_tuser_d      = hdr_tuser_q;
        hdr_tkeep_d      = hdr_tkeep_q;
        hdr_tlast_d      = hdr_tlast_q;
        hdr_valid_d      = hdr_valid_q;
        vlan_id_d        = vlan_id_q;
        seg_tdata_d      = seg_tdata_q;
        seg_tuser_d      = seg_tuser_q;
        seg_tkeep_d      = seg_tkeep_q;
        seg_tlast_d      = seg_tlast_q;
        seg_valid_d      = seg_valid_q;
        stat_pkt_cnt_d   = stat_pkt_cnt_q;
        stat_short_cnt_d = stat_short_cnt_q;
        pop              = 1'b0;
        hdr_xfer         = 1'b0;

        case (state_q)
            S_HDR: begin
                pop = !pkt_fifo_empty;
                if (pop) begin
                    for (int i = 0; i < N; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            hdr_tdata_d[i*DW +: DW] = pkt_fifo_tdata;
                            hdr_tuser_d[i*UW +: UW] = pkt_fifo_tuser;
                            hdr_tkeep_d[i*KW +: KW] = pkt_fifo_tkeep;
                            hdr_tlast_d[i]          = pkt_fifo_tlast;
                        end
                    end
                    // TCI lives in bytes 14/15 in network order; the low
                    // nibble of byte 14 is the top of the VLAN ID.
                    if (idx_q == '0) begin
                        vlan_id_d = C_VLANID_WIDTH'({pkt_fifo_tdata[115:112],
                                                     pkt_fifo_tdata[127:120]});
                    end
                    if (pkt_fifo_tlast || (idx_q == IDX_W'(N - 1))) begin
                        state_d     = S_EMIT;
                        idx_d       = '0;
                        short_d     = pkt_fifo_tlast;
                        hdr_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_EMIT: begin
                // Header and VLAN ID leave as one joint transfer.
                hdr_xfer = hdr_ready && vlan_ready;
                if (hdr_xfer) begin
                    hdr_valid_d    = 1'b0;
                    hdr_tdata_d    = '0;
                    hdr_tuser_d    = '0;
                    hdr_tkeep_d    = '0;
                    hdr_tlast_d    = '0;
                    stat_pkt_cnt_d = stat_pkt_cnt_q + 1'b1;
                    if (short_q) begin
                        stat_short_cnt_d = stat_short_cnt_q + 1'b1;
                        state_d          = S_HDR;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                pop = !pkt_fifo_empty && (!seg_valid_q || seg_ready);
                if (pop && pkt_fifo_tlast) begin
                    state_d = S_HDR;
                end
            end

            default: state_d = S_HDR;
        endcase

        // Payload register: a pop refills it (even in the same cycle the
        // consumer takes the old beat); otherwise an accepted beat empties it.
        // This runs in every state so the final beat drains during S_HDR.
        if ((state_q == S_PAYLOAD) && pop) begin
            seg_tdata_d = pkt_fifo_tdata;
            seg_tuser_d = pkt_fifo_tuser;
            seg_tkeep_d = pkt_fifo_tkeep;
            seg_tlast_d = pkt_fifo_tlast;
            seg_valid_d = 1'b1;
        end else if (seg_ready) begin
            seg_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their *_d values from the same edge.
    // NOTE: the header slots are ordinary flops and are reset, because a slot
    // not written for a short packet must read back as zero.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q          <= S_HDR;
            idx_q            <= '0;
            short_q          <= 1'b0;
            hdr_tdata_q      <= '0;
            hdr_tuser_q      <= '0;
            hdr_tkeep_q      <= '0;
            hdr_tlast_q      <= '0;
            hdr_valid_q      <= 1'b0;
            vlan_id_q        <= '0;
            seg_tdata_q      <= '0;
            seg_tuser_q      <= '0;
            seg_tkeep_q      <= '0;
            seg_tlast_q      <= 1'b0;
            seg_valid_q      <= 1'b0;
            stat_pkt_cnt_q   <= '0;
            stat_short_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            short_q          <= short_d;
            hdr_tdata_q      <= hdr_tdata_d;
            hdr_tuser_q      <= hdr_tuser_d;
            hdr_tkeep_q      <= hdr_tkeep_d;
            hdr_tlast_q      <= hdr_tlast_d;
            hdr_valid_q      <= hdr_valid_d;
            vlan_id_q        <= vlan_id_d;
            seg_tdata_q      <= seg_tdata_d;
            seg_tuser_q      <= seg_tuser_d;
            seg_tkeep_q      <= seg_tkeep_d;
            seg_tlast_q      <= seg_tlast_d;
            seg_valid_q      <= seg_valid_d;
            stat_pkt_cnt_q   <= stat_pkt_cnt_d;
            stat_short_cnt_q <= stat_short_cnt_d;
        end
    end

    assign hdr_tdata      = hdr_tdata_q;
    assign hdr_tuser      = hdr_tuser_q;
    assign hdr_tkeep      = hdr_tkeep_q;
    assign hdr_tlast      = hdr_tlast_q;
    assign hdr_valid      = hdr_valid_q;
    assign vlan_id        = vlan_id_q;
    assign seg_tdata      = seg_tdata_q;
    assign seg_tuser      = seg_tuser_q;
    assign seg_tkeep      = seg_tkeep_q;
    assign seg_tlast      = seg_tlast_q;
    assign seg_valid      = seg_valid_q;
    assign stat_pkt_cnt   = stat_pkt_cnt_q;
    assign stat_short_cnt = stat_short_cnt_q;

endmodule

// File: tb/tb_depar_seg_splitter.sv
// -----------------------------------------------------------------------------
// tb_depar_seg_splitter
//
// Drives two instances (4-beat header and 1-beat header) from small
// fall-through FIFO models. Expected headers and payload beats are queued when
// a packet is pushed and compared when the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_depar_seg_splitter;

    localparam int DW = 128;
    localparam int UW = 16;
    localparam int KW = DW / 8;
    localparam int N4 = 4;
    localparam int SW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [N4*DW-1:0] data;
        logic [N4*UW-1:0] user;
        logic [N4*KW-1:0] keep;
        logic [N4-1:0]    last;
        logic [11:0]      vid;
    } hdr_exp_t;

    typedef struct {
        int          nbeats;
        logic [11:0] vid;
        bit          vlan_stall;
        bit          seg_tog;
        bit          b2b;
        bit          exp_short;
        int          exp_seg;
    } vec_t;

    logic clk = 1'b0;
    logic aresetn = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance with 4 header beats ----------------
    beat_t       mem0 [256];
    logic [7:0]  wr_ptr0 = 8'd0;
    logic [7:0]  rd_ptr0;
    logic [DW-1:0]    pkt_fifo_tdata;
    logic [UW-1:0]    pkt_fifo_tuser;
    logic [KW-1:0]    pkt_fifo_tkeep;
    logic             pkt_fifo_tlast, pkt_fifo_empty, pkt_fifo_rd_en;
    logic [N4*DW-1:0] hdr_tdata;
    logic [N4*UW-1:0] hdr_tuser;
    logic [N4*KW-1:0] hdr_tkeep;
    logic [N4-1:0]    hdr_tlast;
    logic             hdr_valid;
    logic             hdr_ready = 1'b1;
    logic             vlan_ready = 1'b1;
    logic [11:0]      vlan_id;
    logic [DW-1:0]    seg_tdata;
    logic [UW-1:0]    seg_tuser;
    logic [KW-1:0]    seg_tkeep;
    logic             seg_tlast, seg_valid;
    logic             seg_ready = 1'b1;
    logic             seg_toggle = 1'b0;
    logic [SW-1:0]    stat_pkt_cnt, stat_short_cnt;

    assign pkt_fifo_empty = (rd_ptr0 == wr_ptr0);
    assign pkt_fifo_tdata = mem0[rd_ptr0].data;
    assign pkt_fifo_tuser = mem0[rd_ptr0].user;
    assign pkt_fifo_tkeep = mem0[rd_ptr0].keep;
    assign pkt_fifo_tlast = mem0[rd_ptr0].last;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn)                             rd_ptr0 <= 8'd0;
        else if (pkt_fifo_rd_en && !pkt_fifo_empty) rd_ptr0 <= rd_ptr0 + 8'd1;
    end

    depar_seg_splitter #(
        .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_NUM_HDR_BEATS(N4),
        .C_VLANID_WIDTH(12), .C_STAT_WIDTH(SW)
    ) dut (
        .axis_clk(clk), .aresetn(aresetn),
        .pkt_fifo_tdata(pkt_fifo_tdata), .pkt_fifo_tuser(pkt_fifo_tuser),
        .pkt_fifo_tkeep(pkt_fifo_tkeep), .pkt_fifo_tlast(pkt_fifo_tlast),
        .pkt_fifo_empty(pkt_fifo_empty), .pkt_fifo_rd_en(pkt_fifo_rd_en),
        .hdr_tdata(hdr_tdata), .hdr_tuser(hdr_tuser), .hdr_tkeep(hdr_tkeep),
        .hdr_tlast(hdr_tlast), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .vlan_id(vlan_id), .vlan_ready(vlan_ready),
        .seg_tdata(seg_tdata), .seg_tuser(seg_tuser), .seg_tkeep(seg_tkeep),
        .seg_tlast(seg_tlast), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .stat_pkt_cnt(stat_pkt_cnt), .stat_short_cnt(stat_short_cnt)
    );

    // ---------------- instance with 1 header beat ----------------
    beat_t       mem1 [256];
    logic [7:0]  wr_ptr1 = 8'd0;
    logic [7:0]  rd_ptr1;
    logic [DW-1:0] f1_tdata;
    logic [UW-1:0] f1_tuser;
    logic [KW-1:0] f1_tkeep;
    logic          f1_tlast, f1_empty, f1_rd_en;
    logic [DW-1:0] hdr1_tdata;
    logic [UW-1:0] hdr1_tuser;
    logic [KW-1:0] hdr1_tkeep;
    logic [0:0]    hdr1_tlast;
    logic          hdr1_valid;
    logic          ready1 = 1'b1;
    logic [11:0]   vlan1_id;
    logic [DW-1:0] seg1_tdata;
    logic [UW-1:0] seg1_tuser;
    logic [KW-1:0] seg1_tkeep;
    logic          seg1_tlast, seg1_valid;
    logic [SW-1:0] stat1_pkt_cnt, stat1_short_cnt;

    assign f1_empty = (rd_ptr1 == wr_ptr1);
    assign f1_tdata = mem1[rd_ptr1].data;
    assign f1_tuser = mem1[rd_ptr1].user;
    assign f1_tkeep = mem1[rd_ptr1].keep;
    assign f1_tlast = mem1[rd_ptr1].last;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn)               rd_ptr1 <= 8'd0;
        else if (f1_rd_en && !f1_empty) rd_ptr1 <= rd_ptr1 + 8'd1;
    end

    depar_seg_splitter #(
        .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_NUM_HDR_BEATS(1),
        .C_VLANID_WIDTH(12), .C_STAT_WIDTH(SW)
    ) dut1 (
        .axis_clk(clk), .aresetn(aresetn),
        .pkt_fifo_tdata(f1_tdata), .pkt_fifo_tuser(f1_tuser),
        .pkt_fifo_tkeep(f1_tkeep), .pkt_fifo_tlast(f1_tlast),
        .pkt_fifo_empty(f1_empty), .pkt_fifo_rd_en(f1_rd_en),
        .hdr_tdata(hdr1_tdata), .hdr_tuser(hdr1_tuser), .hdr_tkeep(hdr1_tkeep),
        .hdr_tlast(hdr1_tlast), .hdr_valid(hdr1_valid), .hdr_ready(ready1),
        .vlan_id(vlan1_id), .vlan_ready(ready1),
        .seg_tdata(seg1_tdata), .seg_tuser(seg1_tuser), .seg_tkeep(seg1_tkeep),
        .seg_tlast(seg1_tlast), .seg_valid(seg1_valid), .seg_ready(ready1),
        .stat_pkt_cnt(stat1_pkt_cnt), .stat_short_cnt(stat1_short_cnt)
    );

    // ---------------- helpers ----------------
    hdr_exp_t hdr_q [$];
    beat_t    seg_q [$];
    int       seg_seen = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int pkt, input int i, input int nb, input logic [11:0] vid);
        beat_t b;
        for (int k = 0; k < KW; k++) b.data[8*k +: 8] = 8'(pkt * 17 + i * 5 + k);
        if (i == 0) begin
            b.data[119:112] = {4'(pkt), vid[11:8]};
            b.data[127:120] = vid[7:0];
        end
        b.user = 16'(pkt * 256 + i);
        b.keep = (i == nb - 1) ? 16'h0FFF : 16'hFFFF;
        b.last = (i == nb - 1);
        return b;
    endfunction

    task automatic push_pkt(input int pkt, input int nb, input logic [11:0] vid);
        hdr_exp_t e;
        beat_t    b;
        e.data = '0; e.user = '0; e.keep = '0; e.last = '0; e.vid = vid;
        for (int i = 0; i < nb; i++) begin
            b = mk_beat(pkt, i, nb, vid);
            mem0[wr_ptr0] = b;
            wr_ptr0 = wr_ptr0 + 8'd1;
            if (i < N4) begin
                e.data[i*DW +: DW] = b.data;
                e.user[i*UW +: UW] = b.user;
                e.keep[i*KW +: KW] = b.keep;
                e.last[i]          = b.last;
            end else begin
                seg_q.push_back(b);
            end
        end
        hdr_q.push_back(e);
    endtask

    task automatic push_pkt1(input int pkt, input int nb, input logic [11:0] vid);
        for (int i = 0; i < nb; i++) begin
            mem1[wr_ptr1] = mk_beat(pkt, i, nb, vid);
            wr_ptr1 = wr_ptr1 + 8'd1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((hdr_q.size() != 0 || seg_q.size() != 0 || seg_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", (hdr_q.size() == 0 && seg_q.size() == 0 && !seg_valid), 1);
        @(posedge clk); #1;
    endtask

    // seg_ready: steady high, or toggling every cycle when seg_toggle is set
    always @(posedge clk) begin
        #1;
        seg_ready = seg_toggle ? ~seg_ready : 1'b1;
    end

    // scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin : mon
        hdr_exp_t e;
        beat_t    b;
        if (aresetn) begin
            if (hdr_valid && hdr_ready && vlan_ready) begin
                if (hdr_q.size() == 0) begin
                    check("hdr_unexpected", 1, 0);
                end else begin
                    e = hdr_q.pop_front();
                    check("hdr_tdata", hdr_tdata, e.data);
                    check("hdr_tuser", hdr_tuser, e.user);
                    check("hdr_tkeep", hdr_tkeep, e.keep);
                    check("hdr_tlast", hdr_tlast, e.last);
                    check("vlan_id",   vlan_id,   e.vid);
                end
            end
            if (seg_valid && seg_ready) begin
                seg_seen = seg_seen + 1;
                if (seg_q.size() == 0) begin
                    check("seg_unexpected", 1, 0);
                end else begin
                    b = seg_q.pop_front();
                    check("seg_tdata", seg_tdata, b.data);
                    check("seg_tuser", seg_tuser, b.user);
                    check("seg_tkeep", seg_tkeep, b.keep);
                    check("seg_tlast", seg_tlast, b.last);
                end
            end
            if (seg_valid && !seg_ready) check("no_pop_while_seg_stalled", pkt_fifo_rd_en, 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t        vecs [6];
        logic [8:0]  exp_hv, exp_rd, exp_sv;
        int          n_pkt_exp, n_short_exp, seg_mark, seg_acc, t;
        logic [0:0]  hl [4];
        logic [11:0] hv [4];
        logic [DW-1:0] hd [4];
        logic [DW-1:0] sd [4];
        int          nh, ns;

        //          nbeats vid     stall tog b2b short seg
        vecs[0] = '{2,  12'h123, 0, 0, 1, 1, 0};
        vecs[1] = '{5,  12'h456, 0, 0, 0, 0, 1};
        vecs[2] = '{5,  12'h789, 1, 0, 0, 0, 1};
        vecs[3] = '{14, 12'hFED, 0, 1, 0, 0, 10};
        vecs[4] = '{4,  12'h001, 0, 0, 0, 1, 0};
        vecs[5] = '{1,  12'h800, 0, 0, 0, 1, 0};

        #2 aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_seg_valid", seg_valid, 0);
        check("rst_rd_en",     pkt_fifo_rd_en, 0);
        check("rst_pkt_cnt",   stat_pkt_cnt, 0);
        check("rst_short_cnt", stat_short_cnt, 0);
        check("rst_hdr_tdata", hdr_tdata, 0);
        check("rst_vlan_id",   vlan_id, 0);
        check("rst_seg_tdata", seg_tdata, 0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // 6-beat packet, all ready: header in cycle 4, payload valid from cycle 6
        push_pkt(0, 6, 12'hABC);
        exp_hv = 9'b000010000;
        exp_rd = 9'b001101111;
        exp_sv = 9'b011000000;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("t6_hdr_valid_c%0d", k), hdr_valid, exp_hv[k]);
            check($sformatf("t6_rd_en_c%0d", k), pkt_fifo_rd_en, exp_rd[k]);
            check($sformatf("t6_seg_valid_c%0d", k), seg_valid, exp_sv[k]);
        end
        check("t6_pkt_cnt", stat_pkt_cnt, 1);
        check("t6_short_cnt", stat_short_cnt, 0);
        drain();
        n_pkt_exp   = 1;
        n_short_exp = 0;

        // table-driven packets
        seg_mark = seg_seen;
        seg_acc  = 0;
        for (int i = 0; i < 6; i++) begin
            seg_toggle = vecs[i].seg_tog;
            if (vecs[i].vlan_stall) vlan_ready = 1'b0;
            push_pkt(10 + i, vecs[i].nbeats, vecs[i].vid);
            n_pkt_exp   = n_pkt_exp + 1;
            n_short_exp = n_short_exp + int'(vecs[i].exp_short);
            seg_acc     = seg_acc + vecs[i].exp_seg;
            if (vecs[i].vlan_stall) begin
                t = 0;
                while (!hdr_valid && t < 50) begin @(negedge clk); t++; end
                check("stall_hdr_seen", hdr_valid, 1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_hdr_valid", hdr_valid, 1);
                    check("stall_rd_en", pkt_fifo_rd_en, 0);
                    check("stall_pkt_cnt", stat_pkt_cnt, n_pkt_exp - 1);
                    check("stall_hdr_tdata", hdr_tdata, hdr_q[0].data);
                    check("stall_vlan_id", vlan_id, vecs[i].vid);
                end
                @(posedge clk); #1;
                vlan_ready = 1'b1;
            end
            if (!vecs[i].b2b) begin
                drain();
                seg_toggle = 1'b0;
                check($sformatf("vec%0d_seg_beats", i), seg_seen - seg_mark, seg_acc);
                check($sformatf("vec%0d_pkt_cnt", i), stat_pkt_cnt, n_pkt_exp);
                check($sformatf("vec%0d_short_cnt", i), stat_short_cnt, n_short_exp);
                seg_mark = seg_seen;
                seg_acc  = 0;
            end
        end

        // reset after two header beats of a packet
        push_pkt(30, 6, 12'h321);
        repeat (3) @(negedge clk);
        aresetn = 1'b0;
        hdr_q.delete();
        seg_q.delete();
        wr_ptr0 = 8'd0;
        wr_ptr1 = 8'd0;
        #1;
        check("mrst_hdr_tdata", hdr_tdata, 0);
        check("mrst_hdr_tlast", hdr_tlast, 0);
        check("mrst_hdr_valid", hdr_valid, 0);
        check("mrst_seg_valid", seg_valid, 0);
        check("mrst_rd_en",     pkt_fifo_rd_en, 0);
        check("mrst_vlan_id",   vlan_id, 0);
        check("mrst_pkt_cnt",   stat_pkt_cnt, 0);
        check("mrst_short_cnt", stat_short_cnt, 0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        push_pkt(31, 5, 12'h0F0);
        drain();
        check("post_rst_pkt_cnt", stat_pkt_cnt, 1);
        check("post_rst_short_cnt", stat_short_cnt, 0);

        // single-beat header: 1-beat packet then 3-beat packet
        push_pkt1(50, 1, 12'h111);
        push_pkt1(51, 3, 12'h222);
        nh = 0;
        ns = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (hdr1_valid && nh < 4) begin
                hl[nh] = hdr1_tlast;
                hv[nh] = vlan1_id;
                hd[nh] = hdr1_tdata;
                nh++;
            end
            if (seg1_valid && ns < 4) begin
                sd[ns] = seg1_tdata;
                ns++;
            end
        end
        check("n1_hdr_count", nh, 2);
        check("n1_seg_count", ns, 2);
        if (nh == 2) begin
            check("n1_tlast0", hl[0], 1'b1);
            check("n1_tlast1", hl[1], 1'b0);
            check("n1_vlan0", hv[0], 12'h111);
            check("n1_vlan1", hv[1], 12'h222);
            check("n1_hdr_tdata0", hd[0], mk_beat(50, 0, 1, 12'h111).data);
        end
        if (ns == 2) begin
            check("n1_seg0", sd[0], mk_beat(51, 1, 3, 12'h222).data);
            check("n1_seg1", sd[1], mk_beat(51, 2, 3, 12'h222).data);
        end
        check("n1_pkt_cnt", stat1_pkt_cnt, 2);
        check("n1_short_cnt", stat1_short_cnt, 1);

        check("hdr_queue_empty", hdr_q.size(), 0);
        check("seg_queue_empty", seg_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/depar_seg_splitter.md
# depar_seg_splitter

Parametrised successor to the deparser's segment-waiting stage. Pulls packet beats from the fall-through packet FIFO and gathers the first `C_NUM_HDR_BEATS` beats into one wide header word. It extracts the 12-bit VLAN ID, then streams the remaining payload beats through a registered valid/ready output. It sits between the packet FIFO and the header/VLAN/segment FIFOs feeding the deparsing stage, and adds three things to the fixed two-half design:
- configurable header depth;
- short-packet handling;
- per-packet statistics.

## Interface
Parameters:
- `C_AXIS_DATA_WIDTH`, 256, beat data width in bits.
- `C_AXIS_TUSER_WIDTH`, 128, beat tuser width.
- `C_NUM_HDR_BEATS`, 4, beats gathered into the header word; legal range 1..8.
- `C_VLANID_WIDTH`, 12, VLAN ID width.
- `C_STAT_WIDTH`, 32, statistics counter width.

Ports:
- `axis_clk`  in  1  single clock, all logic rising-edge.
- `aresetn`  in  1  asynchronous active-low reset.
- `pkt_fifo_tdata` / `tuser` / `tkeep` / `tlast`  in  DW / UW / DW/8 / 1  head of the fall-through packet FIFO.
- `pkt_fifo_empty`  in  1  packet FIFO empty.
- `pkt_fifo_rd_en`  out  1  pop strobe; the head beat is consumed on any cycle this is high.
- `hdr_tdata`  out  N·DW  header word; beat i occupies `[i*DW +: DW]`.
- `hdr_tuser`  out  N·UW  header tuser, same beat ordering.
- `hdr_tkeep`  out  N·DW/8  header tkeep, same beat ordering.
- `hdr_tlast`  out  N  bit i set when header beat i carried tlast.
- `hdr_valid`  out  1  header word and VLAN ID are valid.
- `hdr_ready`  in  1  header consumer ready.
- `vlan_id`  out  `C_VLANID_WIDTH`  VLAN ID of the current packet.
- `vlan_ready`  in  1  VLAN consumer ready.
- `seg_tdata` / `tuser` / `tkeep` / `tlast`  out  DW / UW / DW/8 / 1  payload beat.
- `seg_valid`  out  1  payload beat valid.
- `seg_ready`  in  1  payload consumer ready.
- `stat_pkt_cnt`  out  `C_STAT_WIDTH`  packets whose header was accepted.
- `stat_short_cnt`  out  `C_STAT_WIDTH`  packets of at most N beats.

## Operation
- **States:** `S_HDR`, `S_EMIT`, `S_PAYLOAD`; reset state is `S_HDR`. A beat index `idx` (width clog2(N), minimum 1) and a `short` flag are held across states.
- **`S_HDR`:**
  - `pkt_fifo_rd_en` = !`pkt_fifo_empty`.
  - On each pop, the beat is written into slot `idx`, its tlast into `hdr_tlast[idx]`, and `idx` increments.
  - The pop at `idx`==N−1, or any pop carrying tlast, moves to `S_EMIT` and clears `idx`.
  - `short` = that pop's tlast.
  - Slots not written for this packet hold zero in tdata, tuser, tkeep and tlast.
- **VLAN ID:**
  - Captured on the pop of slot 0.
  - `vlan_id` = {byte14[3:0], byte15}, where byte k = `tdata[8k+7:8k]`. This is the TCI in network order.
  - Captured unconditionally, regardless of tkeep.
- **`S_EMIT`:**
  - `hdr_valid` = 1 and `pkt_fifo_rd_en` = 0.
  - The handshake completes only when `hdr_ready` && `vlan_ready` in the same cycle. Header and VLAN are a single joint transfer and never partially accepted.
  - On completion: `stat_pkt_cnt`++; if `short`, `stat_short_cnt`++ and go to `S_HDR`; otherwise go to `S_PAYLOAD`.
  - On completion, all header slots are cleared to zero.
- **`S_PAYLOAD`:**
  - `pkt_fifo_rd_en` = !`pkt_fifo_empty` && (!`seg_valid` || `seg_ready`).
  - Each popped beat is registered onto the `seg_*` outputs with `seg_valid` = 1.
  - `seg_valid` drops after a `seg_ready` cycle with no new pop.
  - The pop carrying tlast moves to `S_HDR`. That beat is still presented on `seg_*` and drains while header gathering of the next packet proceeds.
- **Output stability:** `seg_*` and `hdr_*` hold stable while valid && !ready.
- **Counters:** wrap modulo 2^`C_STAT_WIDTH`.

## Timing
- **Reset values:**
  - all `hdr_*`, `seg_*` and `vlan_id` = 0;
  - `hdr_valid` = `seg_valid` = `pkt_fifo_rd_en` = 0;
  - counters = 0; state = `S_HDR`; `idx` = 0.
- **Header latency:** with no stalls, N header pops occur in cycles 0..N−1 and `hdr_valid` rises in cycle N. The earliest handshake is in cycle N.
- **Payload latency:** after the header handshake in cycle t, the first payload pop is in cycle t+1 and `seg_valid` rises in t+2. Throughput is 1 beat/cycle while `seg_ready` = 1.
- **Empty packet FIFO:** stalls in any state without losing the index or state.
- **Reset mid-packet:** asynchronously discards the partial header and any pending payload beat. Upstream FIFOs reset from the same `aresetn`.
- **Simultaneous events:** in `S_PAYLOAD`, a `seg_ready` handshake and a pop in the same cycle replace the register contents with no bubble.

## Test plan
- N=4, one 6-beat packet, VLAN TCI bytes 0x0A,0xBC, all ready = 1 → `hdr_valid` in cycle 4, `vlan_id` = 0xABC, `hdr_tlast` = 4'b0000, 2 seg beats with the last carrying tlast, `stat_pkt_cnt` = 1, `stat_short_cnt` = 0.
- N=4, 2-beat packet → slots 2–3 all zero, `hdr_tlast` = 4'b0010, no `seg_valid`, `stat_short_cnt` = 1. A back-to-back 5-beat packet follows with its header in the next `S_HDR`.
- `hdr_ready` = 1, `vlan_ready` = 0 for 5 cycles → `hdr_valid` held, outputs stable, `pkt_fifo_rd_en` = 0, no counter change until both readies are high.
- 10-beat payload with `seg_ready` toggling 1,0,1,0 → every beat delivered once, in order, with no duplicates or drops. `pkt_fifo_rd_en` never pops while `seg_valid` && !`seg_ready`.
- `aresetn` asserted after 2 header beats → all outputs and counters return to 0 asynchronously. The next full packet after release parses correctly.
- N=1, a 1-beat packet then a 3-beat packet → `hdr_tlast` = 1'b1 then 1'b0, 2 seg beats for the second packet, `stat_short_cnt` = 1.
